serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor: computes diff = in_a - in_b, LSB first, one bit per clock.
//  Companion to the full-adder arithmetic blocks.
//  Used where area matters more than latency (counters, comparators in slow control paths).
//  A single full-subtractor cell plus a borrow flop is reused across WIDTH cycles.
//  Handshake is start/busy/done.
// PARAMETERS
//  WIDTH    8    operand/result width in bits (>=2)
// PORTS
//  sys_clk    in   1      system clock, all logic on rising edge
//  sys_rst_n  in   1      asynchronous active-low reset
//  start      in   1      request; sampled only when busy==0
//  in_a       in   WIDTH  minuend; sampled with accepted start
//  in_b       in   WIDTH  subtrahend; sampled with accepted start
//  busy       out  1      high while an operation is in progress
//  done       out  1      one-cycle pulse: diff/borrow valid
//  diff       out  WIDTH  in_a - in_b modulo 2^WIDTH
//  borrow     out  1      1 when in_a < in_b (unsigned)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, diff=0, borrow=0.
//    All internal shift regs, bit counter and borrow flop are cleared.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE/DONE with start=1 at edge T:
//    - Latch in_a/in_b into shift regs; clear the borrow flop and bit counter.
//    - Go to RUN; busy=1 from the cycle after edge T.
//  - RUN, each edge (WIDTH edges, T+1..T+WIDTH):
//    - d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
//    - Shift a/b right by 1; shift d into the MSB of the result reg (after WIDTH shifts bit0 is in place).
//    - bin <= bout; counter++.
//    - At the edge where counter==WIDTH-1 -> DONE.
//  - DONE (exactly one cycle, after edge T+WIDTH): done=1, busy=0.
//    - diff=result reg; borrow=final bout.
//    - Next edge -> IDLE, or -> RUN if start=1 (back-to-back: the new start is accepted in DONE).
//  - diff/borrow hold their last value until the next DONE; they are not updated mid-operation.
//  - Latency: start sampled at edge T -> done high in the cycle after edge T+WIDTH.
//    Throughput: one result per WIDTH+1 cycles.
//  - start while busy=1: ignored, with no effect on the operation in flight.
//    Operand changes while busy are ignored.
//  - Reset asserted mid-operation: immediate return to reset values.
//    No done pulse; the partial result is discarded.
//  - Width rules:
//    - Counter width is $clog2(WIDTH).
//    - No sign interpretation; borrow is the unsigned underflow flag.
//    - For the signed view, the caller uses diff as two's complement.
// STRUCTURE
//  - Shared package arith_pkg:
//    - FSM state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//    - Default WIDTH constant.
//  - Sub-module full_subtractor (combinational): ports in_1, in_2, bin -> diff, bout.
//    Instantiated once for the per-bit cell.
//  - The top holds the FSM, the two operand shift regs, the result shift reg, the borrow flop and the counter.
// TESTING  (WIDTH=8 unless stated)
//  1. Basic: start with a=100, b=37 -> done 8 cycles after the start edge; diff=63, borrow=0.
//     busy high exactly 8 cycles.
//  2. Underflow: a=5, b=10 -> diff=8'hFB, borrow=1.
//     Also a=0, b=1 -> diff=8'hFF, borrow=1.
//  3. Corners: a=0,b=0 -> 0/0; a=255,b=255 -> 0/0; a=255,b=0 -> 255/0; a=128,b=1 -> 127/0.
//  4. Busy protection: start a=50,b=20; pulse start with a=1,b=2 at cycle 3.
//     -> single done, diff=30, borrow=0.
//  5. Back-to-back: start held high with a new operand each DONE cycle.
//     -> results every 9 cycles, each correct; no lost or duplicated done.
//  6. Reset mid-op: assert sys_rst_n=0 at cycle 4 of a run.
//     -> busy=0, done=0, diff=0, borrow=0; no done pulse.
//     A fresh op after release is correct.
//     Repeat 1-3 with WIDTH=4 and WIDTH=16 against a reference model: a-b mod 2^W.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = in_1 - in_2 - bin, with borrow out.
module full_subtractor (
    input  logic in_1,
    input  logic in_2,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = in_1 ^ in_2 ^ bin;
    assign bout = (~in_1 & in_2) | (~(in_1 ^ in_2) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused over WIDTH
// clocks, LSB first, with a start/busy/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               bin_reg;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               cell_d;
    logic               cell_bout;
    logic               last_bit;
    logic               accept;

    full_subtractor u_cell (
        .in_1 (a_reg[0]),
        .in_2 (b_reg[0]),
        .bin  (bin_reg),
        .diff (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(WIDTH - 1));
    // A new request is taken in IDLE and also in DONE, which gives back-to-back issue.
    assign accept   = (state_reg != ST_RUN) && start;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            diff_reg   <= '0;
            bin_reg    <= 1'b0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            bin_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            res_reg <= {cell_d, res_reg[WIDTH-1:1]};
            bin_reg <= cell_bout;
            cnt_reg <= cnt_reg + 1'b1;
            // Outputs only change on the final bit so callers never see a partial result.
            if (last_bit) begin
                diff_reg   <= {cell_d, res_reg[WIDTH-1:1]};
                borrow_reg <= cell_bout;
            end
        end
    end

    assign busy   = (state_reg == ST_RUN);
    assign done   = (state_reg == ST_DONE);
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule
